// File: rtl/program_loader_pkg.sv
// Shared widths, default geometry and FSM encoding for the boot-load writer.
package program_loader_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned DEF_INST_DEPTH      = 1024;
  localparam int unsigned DEF_DATA_DEPTH      = 1024;
  localparam int unsigned DEF_DATA_PARK_ADDR  = 1023;
  localparam int unsigned DEF_RELEASE_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_I,
    ST_HDR_D,
    ST_LD_I,
    ST_LD_D,
    ST_REL,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/program_loader.sv
// Streams a framed program into the CPU boot port while holding the CPU in
// reset, then releases it. Idle cycles only rewrite harmless values.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INST_DEPTH     = DEF_INST_DEPTH,
  parameter int unsigned DATA_DEPTH     = DEF_DATA_DEPTH,
  parameter int unsigned DATA_PARK_ADDR = DEF_DATA_PARK_ADDR,
  parameter int unsigned RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              cpu_rst,
  output logic [WORD_W-1:0] inst_data_in,
  output logic [WORD_W-1:0] inst_write_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic [WORD_W-1:0] mem_write_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] n_inst_q, n_inst_d;
  logic [WORD_W-1:0] n_data_q, n_data_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] rel_q, rel_d;
  logic [WORD_W-1:0] inst_data_q, inst_data_d;
  logic [WORD_W-1:0] inst_addr_q, inst_addr_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              s_ready_q, s_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  // Next-state, counters and registered port values.
  always_comb begin
    state_d     = state_q;
    n_inst_d    = n_inst_q;
    n_data_d    = n_data_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    inst_data_d = inst_data_q;
    inst_addr_d = inst_addr_q;
    mem_data_d  = mem_data_q;
    mem_addr_d  = mem_addr_q;
    accept      = s_valid && s_ready_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_HDR_I;
      ST_HDR_I: begin
        if (accept) begin
          n_inst_d = s_data;
          state_d  = ST_HDR_D;
        end
      end
      ST_HDR_D: begin
        if (accept) begin
          n_data_d = s_data;
          cnt_d    = '0;
          rel_d    = '0;
          if (n_inst_q > INST_DEPTH || s_data > DATA_DEPTH) state_d = ST_ERR;
          else if (n_inst_q != '0)                         state_d = ST_LD_I;
          else if (s_data != '0)                           state_d = ST_LD_D;
          else                                             state_d = ST_REL;
        end
      end
      ST_LD_I: begin
        if (accept) begin
          inst_data_d = s_data;
          inst_addr_d = cnt_q;
          if (cnt_q == n_inst_q - 32'd1) begin
            cnt_d   = '0;
            state_d = (n_data_q != '0) ? ST_LD_D : ST_REL;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_LD_D: begin
        if (accept) begin
          mem_data_d = s_data;
          mem_addr_d = cnt_q;
          if (cnt_q == n_data_q - 32'd1) begin
            cnt_d   = '0;
            state_d = ST_REL;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_REL: begin
        if (rel_q == 32'(RELEASE_CYCLES - 1)) state_d = ST_RUN;
        else                                  rel_d   = rel_q + 32'd1;
      end
      ST_RUN, ST_ERR: if (start) state_d = ST_HDR_I;
      default: state_d = ST_IDLE;
    endcase

    // Data port parks on a harmless address until the data phase begins.
    if (state_d inside {ST_IDLE, ST_HDR_I, ST_HDR_D, ST_LD_I}) begin
      mem_data_d = '0;
      mem_addr_d = 32'(DATA_PARK_ADDR);
    end

    s_ready_d = state_d inside {ST_HDR_I, ST_HDR_D, ST_LD_I, ST_LD_D};
    busy_d    = state_d inside {ST_HDR_I, ST_HDR_D, ST_LD_I, ST_LD_D, ST_REL};
    done_d    = (state_d == ST_RUN);
    err_d     = (state_d == ST_ERR);
    cpu_rst_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_inst_q    <= '0;
      n_data_q    <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      inst_data_q <= '0;
      inst_addr_q <= '0;
      mem_data_q  <= '0;
      mem_addr_q  <= 32'(DATA_PARK_ADDR);
      s_ready_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_inst_q    <= n_inst_d;
      n_data_q    <= n_data_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      inst_data_q <= inst_data_d;
      inst_addr_q <= inst_addr_d;
      mem_data_q  <= mem_data_d;
      mem_addr_q  <= mem_addr_d;
      s_ready_q   <= s_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign cpu_rst         = cpu_rst_q;
  assign inst_data_in    = inst_data_q;
  assign inst_write_addr = inst_addr_q;
  assign mem_data_in     = mem_data_q;
  assign mem_write_addr  = mem_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked every cycle,
// an emulated CPU memory pair, and directed literal checks.
module tb_program_loader;

  localparam int unsigned RC     = 2;
  localparam int unsigned IDEPTH = 1024;
  localparam int unsigned DDEPTH = 1024;
  localparam logic [31:0] PARK   = 32'd1023;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, cpu_rst, busy, done, err;
  logic [31:0] inst_data_in, inst_write_addr, mem_data_in, mem_write_addr;

  int total = 0;
  int bad   = 0;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .cpu_rst(cpu_rst),
    .inst_data_in(inst_data_in), .inst_write_addr(inst_write_addr),
    .mem_data_in(mem_data_in), .mem_write_addr(mem_write_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model state and emulated CPU memories.
  bit          m_valid = 0;
  int          m_mode, m_prev_mode;
  longint      m_acc, m_ni, m_nd;
  int          m_since;
  bit          m_ready, m_xfer, m_was_run;
  logic [31:0] e_id, e_ia, e_md, e_ma;
  logic [31:0] emu_imem [1024];
  logic [31:0] emu_dmem [1024];
  logic        p_rst_cpu;
  logic [31:0] p_id, p_ia, p_md, p_ma;

  always @(negedge clk) begin
    // The CPU writes whatever the port presented at the edge just passed.
    if (m_valid && p_rst_cpu === 1'b1) begin
      emu_imem[p_ia[9:0]] = p_id;
      emu_dmem[p_ma[9:0]] = p_md;
    end
    if (rst) begin
      m_valid = 1; m_mode = M_IDLE; m_acc = 0; m_ni = 0; m_nd = 0; m_since = 0;
      m_ready = 0;
      e_id = '0; e_ia = '0; e_md = '0; e_ma = PARK;
    end else if (m_valid) begin
      m_prev_mode = m_mode;
      m_xfer      = m_ready && s_valid;
      m_was_run   = (m_mode == M_DONE) && (m_since >= RC);
      if (m_mode == M_DONE && m_since < RC) m_since++;
      if (m_xfer) begin
        if (m_acc == 0) m_ni = longint'(s_data);
        else if (m_acc == 1) begin
          m_nd = longint'(s_data);
          if (m_ni > IDEPTH || m_nd > DDEPTH) m_mode = M_ERR;
        end else if (m_acc < 2 + m_ni) begin
          e_id = s_data; e_ia = 32'(m_acc - 2);
        end else begin
          e_md = s_data; e_ma = 32'(m_acc - 2 - m_ni);
        end
        m_acc++;
        if (m_mode == M_LOAD && m_acc >= 2 && m_acc == 2 + m_ni + m_nd) begin
          m_mode = M_DONE; m_since = 0;
        end
      end
      if (start && (m_prev_mode == M_IDLE || m_prev_mode == M_ERR || m_was_run)) begin
        m_mode = M_LOAD; m_acc = 0;
      end
      if (m_mode == M_IDLE || (m_mode == M_LOAD && (m_acc < 2 || m_acc < 2 + m_ni))) begin
        e_md = '0; e_ma = PARK;
      end
      m_ready = (m_mode == M_LOAD);
    end
    if (m_valid) begin
      chk("s_ready", 32'(s_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_mode == M_LOAD || (m_mode == M_DONE && m_since < RC)));
      chk("done", 32'(done), 32'(m_mode == M_DONE && m_since >= RC));
      chk("cpu_rst", 32'(cpu_rst), 32'(!(m_mode == M_DONE && m_since >= RC)));
      chk("err", 32'(err), 32'(m_mode == M_ERR));
      chk("inst_data", inst_data_in, e_id);
      chk("inst_addr", inst_write_addr, e_ia);
      chk("mem_data", mem_data_in, e_md);
      chk("mem_addr", mem_write_addr, e_ma);
    end
    p_rst_cpu = cpu_rst; p_id = inst_data_in; p_ia = inst_write_addr;
    p_md = mem_data_in; p_ma = mem_write_addr;
  end

  logic [31:0] fr [$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n = 0;
    s_valid = 1'b1; s_data = w;
    while (!s_ready && n < 50) begin tick(); n++; end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got s_ready=0 want 1 at %0t", $time);
    end
    tick();
    s_valid = 1'b0; s_data = $urandom;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input int gap, input bit rnd);
    foreach (fr[i]) send_word(fr[i], rnd ? int'($urandom_range(3, 0)) : gap);
  endtask

  task automatic build_frame(input int ni, input int nd);
    fr.delete();
    fr.push_back(32'(ni));
    fr.push_back(32'(nd));
    repeat (ni + nd) fr.push_back($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got done=0 want 1 at %0t", $time);
    end
  endtask

  task automatic check_mem();
    int ni = int'(fr[0]);
    int nd = int'(fr[1]);
    for (int k = 0; k < ni; k++) chk("imem", emu_imem[k], fr[2 + k]);
    for (int j = 0; j < nd; j++) chk("dmem", emu_dmem[j], fr[2 + ni + j]);
  endtask

  task automatic check_reset_vals();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_inst_data", inst_data_in, 32'd0);
    chk("rst_inst_addr", inst_write_addr, 32'd0);
    chk("rst_mem_data", mem_data_in, 32'd0);
    chk("rst_mem_addr", mem_write_addr, 32'd1023);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals();

    // Basic frame, streaming back to back.
    fr = '{32'd2, 32'd1, 32'hA, 32'hB, 32'h7};
    pulse_start();
    send_frame(0, 0);
    wait_done();
    chk("cpu_fetch_pc0", emu_imem[0], 32'hA);
    chk("imem1", emu_imem[1], 32'hB);
    chk("dmem0", emu_dmem[0], 32'h7);
    chk("park_word", emu_dmem[1023], 32'h0);

    // Restart from RUN with a word offered in the same cycle; gaps of 3.
    s_valid = 1'b1; s_data = 32'd2;
    pulse_start();
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    s_valid = 1'b0;
    send_frame(3, 0);
    wait_done();
    check_mem();
    chk("gap_fetch_pc0", emu_imem[0], 32'hA);

    // Empty frame: release timing from the second header word.
    pulse_start();
    send_word(32'd0, 0);
    s_valid = 1'b1; s_data = 32'd0;
    tick();
    s_valid = 1'b0;
    c = 1;
    while (cpu_rst && c < 20) begin tick(); c++; end
    chk("empty_release_cycles", 32'(c), 32'(RC + 1));

    // Oversized instruction count is rejected; start recovers.
    fr = '{32'(IDEPTH + 1), 32'd0};
    pulse_start();
    send_frame(0, 0);
    repeat (2) tick();
    chk("err_flag", 32'(err), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("err_no_ready", 32'(s_ready), 32'd0);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_hdr_ready", 32'(s_ready), 32'd1);
    build_frame(3, 2);
    send_frame(0, 1);
    wait_done();
    check_mem();

    // Oversized data count.
    fr = '{32'd0, 32'(DDEPTH + 1)};
    pulse_start();
    send_frame(0, 0);
    tick();
    chk("derr_flag", 32'(err), 32'd1);

    // Full instruction depth is legal.
    build_frame(int'(IDEPTH), 1);
    pulse_start();
    send_frame(0, 0);
    wait_done();
    check_mem();

    // Randomized frames with random gaps.
    for (int f = 0; f < 6; f++) begin
      build_frame(int'($urandom_range(20, 0)), int'($urandom_range(20, 0)));
      pulse_start();
      send_frame(0, 1);
      wait_done();
      check_mem();
    end

    // Reset in the middle of the instruction phase.
    fr = '{32'd3, 32'd0, 32'h1234_5678, 32'h2, 32'h3};
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(fr[i], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals();
    repeat (2) tick();
    chk("idle_after_rst", 32'(s_ready), 32'd0);
    build_frame(4, 3);
    pulse_start();
    send_frame(0, 1);
    wait_done();
    check_mem();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
